// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters and
// sequences clock-gate wake-up, enable strobe, result capture and response hand-back.
//
//  state | meaning
//  IDLE  | waiting for a request; READY offered to the prioritised requester
//  WAKE  | ALU clock gate opened one cycle ahead of the strobe
//  EXEC  | ALU_EN strobe, ALU computes into its result register
//  CAPT  | ALU result and OUT_VALID sampled into the response registers
//  RESP  | response presented until RSP_READY
module alu_req_arbiter #(
    parameter int OP_W   = 16,
    parameter int RSLT_W = 16,
    parameter int FUN_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [OP_W-1:0]   REQ0_A,
    input  logic [OP_W-1:0]   REQ0_B,
    input  logic [FUN_W-1:0]  REQ0_FUN,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [OP_W-1:0]   REQ1_A,
    input  logic [OP_W-1:0]   REQ1_B,
    input  logic [FUN_W-1:0]  REQ1_FUN,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic              RSP_ID,
    output logic [RSLT_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic              ALU_CLK_EN,
    output logic              ALU_EN,
    output logic [OP_W-1:0]   ALU_A,
    output logic [OP_W-1:0]   ALU_B,
    output logic [FUN_W-1:0]  ALU_FUN,
    input  logic [RSLT_W-1:0] ALU_OUT,
    input  logic              ALU_OUT_VALID,
    output logic              BUSY
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAKE = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_CAPT = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       prio;
    logic       in_idle;
    logic       accept;
    logic       grant_id;

    // READY is gated by RST so every output reads 0 while reset is held.
    always_comb begin
        in_idle    = RST && (state == ST_IDLE);
        REQ0_READY = in_idle && REQ0_VALID && (!REQ1_VALID || !prio);
        REQ1_READY = in_idle && REQ1_VALID && (!REQ0_VALID ||  prio);
        accept     = REQ0_READY || REQ1_READY;
        grant_id   = REQ1_READY;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_WAKE;
            ST_WAKE:                state_nxt = ST_EXEC;
            ST_EXEC:                state_nxt = ST_CAPT;
            ST_CAPT:                state_nxt = ST_RESP;
            ST_RESP: if (RSP_READY) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Strobe and status outputs are registered from the next state so they line
    // up with the state they describe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            prio       <= 1'b0;
            BUSY       <= 1'b0;
            ALU_CLK_EN <= 1'b0;
            ALU_EN     <= 1'b0;
            RSP_VALID  <= 1'b0;
        end else begin
            state      <= state_nxt;
            BUSY       <= (state_nxt != ST_IDLE);
            ALU_CLK_EN <= (state_nxt == ST_WAKE) || (state_nxt == ST_EXEC) ||
                          (state_nxt == ST_CAPT);
            ALU_EN     <= (state_nxt == ST_EXEC);
            RSP_VALID  <= (state_nxt == ST_RESP);
            if (accept) begin
                prio <= !grant_id;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_A   <= '0;
            ALU_B   <= '0;
            ALU_FUN <= '0;
            RSP_ID  <= 1'b0;
        end else if (accept) begin
            ALU_A   <= grant_id ? REQ1_A   : REQ0_A;
            ALU_B   <= grant_id ? REQ1_B   : REQ0_B;
            ALU_FUN <= grant_id ? REQ1_FUN : REQ0_FUN;
            RSP_ID  <= grant_id;
        end
    end

    // A missing OUT_VALID means the ALU rejected the function code.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RSP_DATA <= '0;
            RSP_ERR  <= 1'b0;
        end else if (state == ST_CAPT) begin
            RSP_DATA <= ALU_OUT_VALID ? ALU_OUT : '0;
            RSP_ERR  <= !ALU_OUT_VALID;
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model and a small ALU model.
module tb_alu_req_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic        REQ0_READY, REQ1_READY;
    logic [15:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
    logic [3:0]  REQ0_FUN = '0, REQ1_FUN = '0;
    logic        RSP_VALID, RSP_READY = 1'b1, RSP_ID, RSP_ERR;
    logic [15:0] RSP_DATA;
    logic        ALU_CLK_EN, ALU_EN, BUSY;
    logic [15:0] ALU_A, ALU_B, ALU_OUT;
    logic [3:0]  ALU_FUN;
    logic        ALU_OUT_VALID;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    alu_req_arbiter #(.OP_W(16), .RSLT_W(16), .FUN_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A),
        .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A),
        .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .ALU_CLK_EN(ALU_CLK_EN), .ALU_EN(ALU_EN), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .BUSY(BUSY)
    );

    // {supported, result}: 0 ADD, 1 SUB, 2 MULT (low 16 bits), 3 AND, 4 OR, 5 XOR.
    function automatic logic [16:0] ref_op(input logic [3:0] fun, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] prod;
        prod = a * b;
        case (fun)
            4'd0:    return {1'b1, a + b};
            4'd1:    return {1'b1, a - b};
            4'd2:    return {1'b1, prod[15:0]};
            4'd3:    return {1'b1, a & b};
            4'd4:    return {1'b1, a | b};
            4'd5:    return {1'b1, a ^ b};
            default: return {1'b0, a ^ 16'hA5A5};
        endcase
    endfunction

    // Gated ALU: result register loads on ALU_EN, OUT_VALID clears on the next enabled cycle.
    logic [16:0] alu_tmp;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_OUT       <= '0;
            ALU_OUT_VALID <= 1'b0;
        end else if (ALU_CLK_EN) begin
            if (ALU_EN) begin
                alu_tmp = ref_op(ALU_FUN, ALU_A, ALU_B);
                ALU_OUT       <= alu_tmp[15:0];
                ALU_OUT_VALID <= alu_tmp[16];
            end else begin
                ALU_OUT_VALID <= 1'b0;
            end
        end
    end

    // Reference model: m_age counts cycles since acceptance (0 = idle, 4 = responding).
    int          m_age;
    logic        m_prio, m_id, m_err, m_pend_err;
    logic [15:0] m_a, m_b, m_data, m_pend_data;
    logic [3:0]  m_fun;
    logic        acc0, acc1;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_prio = 0; m_id = 0; m_err = 0; m_pend_err = 0;
        m_a = '0; m_b = '0; m_fun = '0; m_data = '0; m_pend_data = '0;
    endtask

    function automatic logic exp_rdy(input logic which);
        logic mine, other;
        mine  = which ? REQ1_VALID : REQ0_VALID;
        other = which ? REQ0_VALID : REQ1_VALID;
        return RST && (m_age == 0) && mine && (!other || (m_prio == which));
    endfunction

    task automatic check_outputs();
        chk("req0_ready", REQ0_READY, exp_rdy(1'b0));
        chk("req1_ready", REQ1_READY, exp_rdy(1'b1));
        chk("alu_clk_en", ALU_CLK_EN, (m_age >= 1 && m_age <= 3));
        chk("alu_en",     ALU_EN,     (m_age == 2));
        chk("rsp_valid",  RSP_VALID,  (m_age == 4));
        chk("busy",       BUSY,       (m_age != 0));
        chk("alu_a",      ALU_A,      m_a);
        chk("alu_b",      ALU_B,      m_b);
        chk("alu_fun",    ALU_FUN,    m_fun);
        chk("rsp_id",     RSP_ID,     m_id);
        chk("rsp_data",   RSP_DATA,   m_data);
        chk("rsp_err",    RSP_ERR,    m_err);
    endtask

    // One clock cycle: inputs are already driven; check, cross the edge, advance the model.
    task automatic step();
        logic [16:0] r;
        logic        e0, e1;
        #1;
        check_outputs();
        e0 = exp_rdy(1'b0);
        e1 = exp_rdy(1'b1);
        @(posedge CLK);
        acc0 = 0; acc1 = 0;
        if (!RST) begin
            model_reset();
        end else if (m_age == 0) begin
            if (e0 || e1) begin
                acc0 = e0; acc1 = e1;
                m_id  = e1;
                m_a   = e1 ? REQ1_A   : REQ0_A;
                m_b   = e1 ? REQ1_B   : REQ0_B;
                m_fun = e1 ? REQ1_FUN : REQ0_FUN;
                r = ref_op(m_fun, m_a, m_b);
                m_pend_data = r[16] ? r[15:0] : 16'h0000;
                m_pend_err  = !r[16];
                m_prio = !e1;
                m_age  = 1;
                grants.push_back(int'(e1));
            end
        end else if (m_age < 3) begin
            m_age++;
        end else if (m_age == 3) begin
            m_age = 4; m_data = m_pend_data; m_err = m_pend_err;
        end else if (RSP_READY) begin
            m_age = 0;
        end
        #1;
    endtask

    task automatic drive0(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        REQ0_VALID = 1; REQ0_A = a; REQ0_B = b; REQ0_FUN = f;
    endtask

    task automatic drive1(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        REQ1_VALID = 1; REQ1_A = a; REQ1_B = b; REQ1_FUN = f;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rr_rsp[$];
        int          g0;
        model_reset();

        // Reset state
        #2;
        check_outputs();
        repeat (2) step();
        RST = 1;
        repeat (2) step();

        // Single ADD with exact cycle positions
        drive0(16'h0005, 16'h0003, 4'd0);
        RSP_READY = 1;
        #1 chk("add_ready_n", REQ0_READY, 1);
        step();
        REQ0_VALID = 0;
        chk("add_clken_n1", ALU_CLK_EN, 1); chk("add_en_n1", ALU_EN, 0);
        step();
        chk("add_clken_n2", ALU_CLK_EN, 1); chk("add_en_n2", ALU_EN, 1);
        step();
        chk("add_clken_n3", ALU_CLK_EN, 1); chk("add_en_n3", ALU_EN, 0);
        step();
        chk("add_rspv_n4", RSP_VALID, 1); chk("add_id", RSP_ID, 0);
        chk("add_data", RSP_DATA, 16'h0008); chk("add_err", RSP_ERR, 0);
        chk("add_clken_n4", ALU_CLK_EN, 0);
        step();
        chk("add_idle_n5", BUSY, 0);

        // Round-robin from a fresh reset, both requesters valid continuously
        RST = 0; #1; RST = 1;
        model_reset();
        g0 = grants.size();
        drive0(16'h0010, 16'h0001, 4'd1);
        drive1(16'h0100, 16'h0100, 4'd2);
        for (int i = 0; i < 40 && rr_rsp.size() < 4; i++) begin
            if (RSP_VALID) rr_rsp.push_back({15'd0, RSP_ID, RSP_DATA});
            if (rr_rsp.size() == 4) begin REQ0_VALID = 0; REQ1_VALID = 0; end
            step();
        end
        chk("rr_rsp_count", rr_rsp.size(), 4);
        for (int k = 0; k < 4 && k < rr_rsp.size(); k++) begin
            chk("rr_grant", grants[g0 + k], k % 2);
            chk("rr_rsp", rr_rsp[k], (k % 2) ? 32'h0001_0000 : 32'h0000_000F);
        end
        repeat (2) step();

        // Unsupported function code, then a normal request
        drive1(16'h1234, 16'h0001, 4'd15);
        step();
        REQ1_VALID = 0;
        repeat (3) step();
        chk("unsup_rspv", RSP_VALID, 1); chk("unsup_id", RSP_ID, 1);
        chk("unsup_data", RSP_DATA, 0); chk("unsup_err", RSP_ERR, 1);
        step();
        drive0(16'h0007, 16'h0009, 4'd0);
        step();
        REQ0_VALID = 0;
        repeat (3) step();
        chk("after_unsup_data", RSP_DATA, 16'h0010); chk("after_unsup_err", RSP_ERR, 0);
        step();

        // Response backpressure with REQ1 waiting
        drive0(16'h00FF, 16'h0F0F, 4'd5);
        RSP_READY = 0;
        step();
        REQ0_VALID = 0;
        drive1(16'h0001, 16'h0002, 4'd0);
        repeat (3) step();
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_data", RSP_DATA, 16'h0FF0); chk("bp_rspv", RSP_VALID, 1);
            chk("bp_req1_ready", REQ1_READY, 0); chk("bp_clken", ALU_CLK_EN, 0);
            step();
        end
        RSP_READY = 1;
        step();
        chk("bp_idle_busy", BUSY, 0); chk("bp_idle_rspv", RSP_VALID, 0);
        #1 chk("bp_req1_granted", REQ1_READY, 1);
        step();
        REQ1_VALID = 0;
        repeat (5) step();

        // Reset while in EXEC
        drive0(16'h0011, 16'h0022, 4'd0);
        step();
        REQ0_VALID = 0;
        step();
        chk("mid_in_exec", ALU_EN, 1);
        RST = 0;
        #1;
        chk("mid_en", ALU_EN, 0); chk("mid_clken", ALU_CLK_EN, 0);
        chk("mid_busy", BUSY, 0); chk("mid_rspv", RSP_VALID, 0);
        chk("mid_alu_a", ALU_A, 0); chk("mid_rsp_id", RSP_ID, 0);
        model_reset();
        repeat (3) step();
        RST = 1;
        drive0(16'h00F0, 16'h0FF0, 4'd3);
        drive1(16'h0003, 16'h0004, 4'd2);
        #1;
        chk("mid_prio_r0", REQ0_READY, 1); chk("mid_prio_r1", REQ1_READY, 0);
        step();
        REQ0_VALID = 0;
        repeat (3) step();
        chk("mid_and_rspv", RSP_VALID, 1); chk("mid_and_id", RSP_ID, 0);
        chk("mid_and_data", RSP_DATA, 16'h00F0);
        step();
        step();
        REQ1_VALID = 0;
        repeat (5) step();

        // Random traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            if (!REQ0_VALID && $urandom_range(0, 2) == 0)
                drive0(16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)));
            if (!REQ1_VALID && $urandom_range(0, 2) == 0)
                drive1(16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)));
            RSP_READY = ($urandom_range(0, 3) != 0);
            step();
            if (acc0) REQ0_VALID = 0;
            if (acc1) REQ1_VALID = 0;
        end
        REQ0_VALID = 0; REQ1_VALID = 0; RSP_READY = 1;
        repeat (8) step();
        chk("final_idle", BUSY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
